// File: rtl/mvm_uart_pkg.sv
// Shared constants and types for the UART matrix-vector-multiply system.
//   CLOCKS_PER_PULSE : clk cycles per UART bit (50 MHz / 19200 baud)
//   BITS_PER_WORD    : data bits per UART frame
//   R, C, W_X, W_K   : MVM geometry; W_OUT is the packed operand width (K matrix + X vector)
//   rx_state_e       : receiver FSM encoding
//   num_words()      : bytes needed to carry one packed operand word
package mvm_uart_pkg;

  localparam int unsigned CLOCKS_PER_PULSE = 2604;
  localparam int unsigned BITS_PER_WORD    = 8;

  localparam int unsigned R   = 2;
  localparam int unsigned C   = 2;
  localparam int unsigned W_X = 4;
  localparam int unsigned W_K = 2;

  localparam int unsigned W_OUT = R * C * W_K + C * W_X;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_e;

  // Ceiling division: bytes per packet.
  function automatic int unsigned num_words(input int unsigned w_out, input int unsigned bpw);
    return (w_out + bpw - 1) / bpw;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, baud counter, FSM and LSB-first shift register.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   rx         : asynchronous UART line, idle high
//   rx_byte    : last received data byte (valid while byte_valid is high)
//   byte_valid : one-cycle pulse, stop bit sampled high
//   frame_err  : one-cycle pulse, stop bit sampled low (byte dropped)
module uart_rx_byte #(
  parameter int unsigned CLOCKS_PER_PULSE = mvm_uart_pkg::CLOCKS_PER_PULSE,
  parameter int unsigned BITS_PER_WORD    = mvm_uart_pkg::BITS_PER_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] rx_byte,
  output logic                     byte_valid,
  output logic                     frame_err
);

  import mvm_uart_pkg::*;

  localparam int unsigned CntW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int unsigned BitW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;

  localparam logic [CntW-1:0] HalfLast = CntW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(BITS_PER_WORD - 1);

  logic                     sync_q, rx_s_q;
  rx_state_e                state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [BitW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_WORD-1:0] shreg_q, shreg_d;
  logic                     byte_valid_q, byte_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     half_tick, full_tick;

  assign half_tick = (cnt_q == HalfLast);
  assign full_tick = (cnt_q == FullLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= rx;
      rx_s_q       <= sync_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        // Re-check the line mid start bit to reject glitches.
        if (half_tick) begin
          cnt_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (full_tick) begin
          cnt_d     = '0;
          shreg_d   = (shreg_q >> 1) | (BITS_PER_WORD'(rx_s_q) << (BITS_PER_WORD - 1));
          bit_cnt_d = bit_cnt_q + BitW'(1);
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = StStop;
          end
        end
      end
      StStop: begin
        if (full_tick) begin
          cnt_d   = '0;
          state_d = rx_s_q ? StIdle : StWaitIdle;
        end
      end
      StWaitIdle: begin
        // Line stuck low after a bad stop bit: wait for idle before hunting again.
        cnt_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    byte_valid_d = (state_q == StStop) && full_tick && rx_s_q;
    frame_err_d  = (state_q == StStop) && full_tick && !rx_s_q;
  end

  assign rx_byte    = shreg_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_rx_packer.sv
// UART receive path for the MVM core: receives 8N1 bytes, packs them LSB-first into one
// W_OUT-bit operand word and presents it on a valid/ready stream.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   rx        : asynchronous UART line, idle high
//   m_data    : packed operand word
//   m_valid   : m_data valid
//   m_ready   : consumer accepts word when m_valid && m_ready
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, packet completed while the output word was still held
module uart_rx_packer #(
  parameter int unsigned CLOCKS_PER_PULSE = mvm_uart_pkg::CLOCKS_PER_PULSE,
  parameter int unsigned BITS_PER_WORD    = mvm_uart_pkg::BITS_PER_WORD,
  parameter int unsigned W_OUT            = mvm_uart_pkg::W_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [W_OUT-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             frame_err,
  output logic             overrun
);

  import mvm_uart_pkg::*;

  localparam int unsigned NUM_WORDS = num_words(W_OUT, BITS_PER_WORD);
  localparam int unsigned AsmW      = NUM_WORDS * BITS_PER_WORD;
  localparam int unsigned ByteCntW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [ByteCntW-1:0] ByteLast = ByteCntW'(NUM_WORDS - 1);

  logic [BITS_PER_WORD-1:0] rx_byte;
  logic                     byte_valid;
  logic                     rx_frame_err;

  logic [AsmW-1:0]     asm_q, asm_d;
  logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
  logic                pkt_done_q, pkt_done_d;
  logic [W_OUT-1:0]    m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                overrun_q, overrun_d;

  uart_rx_byte #(
    .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
    .BITS_PER_WORD    (BITS_PER_WORD)
  ) u_rx_byte (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (rx_frame_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q      <= '0;
      byte_cnt_q <= '0;
      pkt_done_q <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
      pkt_done_q <= pkt_done_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Assembly: byte n lands in bits [8n+7:8n]; a framing error restarts the packet.
  always_comb begin
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    pkt_done_d = 1'b0;
    if (rx_frame_err) begin
      byte_cnt_d = '0;
    end else if (byte_valid) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        if (byte_cnt_q == ByteCntW'(i)) asm_d[i*BITS_PER_WORD +: BITS_PER_WORD] = rx_byte;
      end
      if (byte_cnt_q == ByteLast) begin
        byte_cnt_d = '0;
        pkt_done_d = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + ByteCntW'(1);
      end
    end
  end

  // Output register: a completed packet loads only if the slot is free or being emptied now.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    overrun_d = 1'b0;
    if (pkt_done_q) begin
      if (!m_valid_q || m_ready) begin
        m_data_d  = asm_q[W_OUT-1:0];
        m_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Padding bits of the last byte beyond W_OUT are discarded.
  if (AsmW > W_OUT) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^asm_q[AsmW-1:W_OUT];
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign frame_err = rx_frame_err;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Self-checking bench for uart_rx_packer (CLOCKS_PER_PULSE = 16). Expected words are queued
// as frames are driven and compared whenever the DUT hands off a word.
module tb_uart_rx_packer;

  localparam int unsigned Cpp = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        frame_err;
  logic        overrun;

  int unsigned num_checks = 0;
  int unsigned num_fail   = 0;
  int unsigned fe_cnt     = 0;
  int unsigned ov_cnt     = 0;
  logic [15:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  uart_rx_packer #(
    .CLOCKS_PER_PULSE (Cpp),
    .BITS_PER_WORD    (8),
    .W_OUT            (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge, clear of both clock edges.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    step(Cpp);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step(1);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: every handshake must match the oldest queued word; pulses are counted.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() != 0) mon_exp = {16'h0, exp_q.pop_front()};
        else mon_exp = 'x;
        check("m_data_handoff", {16'h0, m_data}, mon_exp);
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  initial begin
    rst     = 1'b1;
    rx      = 1'b1;
    m_ready = 1'b1;
    step(3);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    step(5);

    // Basic two-byte packet.
    exp_q.push_back(16'h3CA5);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    drain("t1_drain");
    check("t1_frame_err", fe_cnt, 0);
    check("t1_overrun", ov_cnt, 0);

    // Start-bit glitch must not produce a byte.
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(20);
    exp_q.push_back(16'h2211);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    drain("t2_drain");

    // Framing error after a good first byte restarts the packet.
    send_byte(8'h77, 1'b1);
    send_byte(8'h55, 1'b0);
    rx = 1'b0;
    step(40);
    rx = 1'b1;
    step(20);
    check("t3_frame_err_cnt", fe_cnt, 1);
    exp_q.push_back(16'h0201);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    drain("t3_drain");
    check("t3_frame_err_final", fe_cnt, 1);

    // Backpressure: second packet overruns, held word unchanged.
    m_ready = 1'b0;
    send_byte(8'h0F, 1'b1);
    send_byte(8'hF0, 1'b1);
    step(4);
    check("t4_valid_held", m_valid, 1);
    check("t4_data_held", m_data, 16'hF00F);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    step(4);
    check("t4_overrun_cnt", ov_cnt, 1);
    check("t4_data_kept", m_data, 16'hF00F);
    check("t4_valid_kept", m_valid, 1);
    exp_q.push_back(16'hF00F);
    m_ready = 1'b1;
    step(1);
    check("t4_valid_drop", m_valid, 0);
    drain("t4_drain");

    // Handoff in the exact cycle the next packet loads (stop sample of 2nd byte at +155).
    m_ready = 1'b0;
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    step(4);
    check("t5_data_held", m_data, 16'h3344);
    exp_q.push_back(16'h3344);
    exp_q.push_back(16'h5566);
    send_byte(8'h66, 1'b1);
    fork
      send_byte(8'h55, 1'b1);
      begin
        step(156);
        m_ready = 1'b1;
        step(1);
        check("t5_valid_stays", m_valid, 1);
        check("t5_data_new", m_data, 16'h5566);
      end
    join
    drain("t5_drain");
    check("t5_overrun_cnt", ov_cnt, 1);

    // Reset with a held word, one buffered byte and a frame in progress.
    m_ready = 1'b0;
    send_byte(8'h9A, 1'b1);
    send_byte(8'hBC, 1'b1);
    step(4);
    check("t6_valid_before_rst", m_valid, 1);
    send_byte(8'h99, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b0;
    step(8);
    rst = 1'b1;
    rx  = 1'b1;
    step(3);
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_data", m_data, 0);
    rst     = 1'b0;
    m_ready = 1'b1;
    step(20);
    exp_q.push_back(16'h3412);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    drain("t6_drain");
    check("t6_frame_err_cnt", fe_cnt, 1);
    check("t6_overrun_cnt", ov_cnt, 1);

    step(5);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
